// File: rtl/channel_window_stats_pkg.sv
// ---------------------------------------------------------------------------
// ch_stats_pkg
// Shared sizing and state encoding for the per-channel sample window buffer
// and its downstream statistics reader.
//   NUM_CHANNELS : channels held in the buffer
//   SAMPLE_BITS  : width of one sample
//   WINDOW       : samples per channel window
//   CH_W/SLOT_W  : channel / slot index widths
//   SUM_W        : accumulator width, wide enough that a full window of
//                  maximum samples cannot overflow
// ---------------------------------------------------------------------------
package ch_stats_pkg;

  localparam int NUM_CHANNELS = 14;
  localparam int SAMPLE_BITS  = 8;
  localparam int WINDOW       = 10;
  localparam int CH_W         = $clog2(NUM_CHANNELS);
  localparam int SLOT_W       = $clog2(WINDOW);
  localparam int SUM_W        = SAMPLE_BITS + $clog2(WINDOW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

endpackage

// File: rtl/channel_window_stats_accum.sv
// ---------------------------------------------------------------------------
// window_accum
// Running sum / min / max over the samples of one window.
//   clk, reset : clock, synchronous active-high reset
//   i_clear    : zero all results (start of a new request)
//   i_valid    : i_data holds a sample this cycle
//   i_first    : this sample is the first of the window (loads, not merges)
//   i_data     : sample value (unsigned)
//   o_sum      : zero-extended sum of accepted samples
//   o_min      : smallest sample seen (ties keep current value)
//   o_max      : largest sample seen (ties keep current value)
// ---------------------------------------------------------------------------
module window_accum
  import ch_stats_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_clear,
  input  logic                   i_valid,
  input  logic                   i_first,
  input  logic [SAMPLE_BITS-1:0] i_data,
  output logic [SUM_W-1:0]       o_sum,
  output logic [SAMPLE_BITS-1:0] o_min,
  output logic [SAMPLE_BITS-1:0] o_max
);

  logic [SUM_W-1:0]       r_sum;
  logic [SAMPLE_BITS-1:0] r_min;
  logic [SAMPLE_BITS-1:0] r_max;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_sum <= '0;
      r_min <= '0;
      r_max <= '0;
    end else if (i_valid) begin
      if (i_first) begin
        r_sum <= SUM_W'(i_data);
        r_min <= i_data;
        r_max <= i_data;
      end else begin
        r_sum <= r_sum + SUM_W'(i_data);
        if (i_data < r_min) r_min <= i_data;
        if (i_data > r_max) r_max <= i_data;
      end
    end
  end

  assign o_sum = r_sum;
  assign o_min = r_min;
  assign o_max = r_max;

endmodule

// File: rtl/channel_window_stats.sv
// ---------------------------------------------------------------------------
// channel_window_stats
// On request, sweeps every slot of one channel through the sample buffer's
// synchronous read port and returns sum/min/max of that window. One request
// in flight; the result is held until the downstream consumer takes it.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake, req_ready high only in IDLE
//   req_chan            : channel to read (>= NUM_CHANNELS flags res_err)
//   rd_en/rd_chan/rd_slot : buffer read port, slot 0 = oldest sample
//   rd_data             : buffer read data, valid one cycle after rd_en
//   res_valid/res_ready : result handshake
//   res_chan/res_sum/res_min/res_max/res_err : held result
// ---------------------------------------------------------------------------
module channel_window_stats
  import ch_stats_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [CH_W-1:0]        req_chan,
  output logic                   rd_en,
  output logic [CH_W-1:0]        rd_chan,
  output logic [SLOT_W-1:0]      rd_slot,
  input  logic [SAMPLE_BITS-1:0] rd_data,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [CH_W-1:0]        res_chan,
  output logic [SUM_W-1:0]       res_sum,
  output logic [SAMPLE_BITS-1:0] res_min,
  output logic [SAMPLE_BITS-1:0] res_max,
  output logic                   res_err
);

  state_t              r_state;
  logic                r_req_ready;
  logic                r_rd_en;
  logic [CH_W-1:0]     r_rd_chan;
  logic [SLOT_W-1:0]   r_rd_slot;
  logic                r_rd_en_d;
  logic                r_first_d;
  logic                r_res_valid;
  logic [CH_W-1:0]     r_res_chan;
  logic                r_res_err;
  logic                w_start;

  assign w_start = req_valid && r_req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_req_ready <= 1'b1;
      r_rd_en     <= 1'b0;
      r_rd_chan   <= '0;
      r_rd_slot   <= '0;
      r_rd_en_d   <= 1'b0;
      r_first_d   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_chan  <= '0;
      r_res_err   <= 1'b0;
    end else begin
      // Buffer read latency is one cycle: the delayed strobe marks valid data.
      r_rd_en_d <= r_rd_en;
      r_first_d <= r_rd_en && (r_rd_slot == '0);
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_req_ready <= 1'b0;
            r_res_chan  <= req_chan;
            if (req_chan >= CH_W'(NUM_CHANNELS)) begin
              // Bad channel: no sweep, zeroed stats come from the accum clear.
              r_res_err   <= 1'b1;
              r_res_valid <= 1'b1;
              r_state     <= HOLD;
            end else begin
              r_res_err <= 1'b0;
              r_rd_chan <= req_chan;
              r_rd_slot <= '0;
              r_rd_en   <= 1'b1;
              r_state   <= READ;
            end
          end
        end
        READ: begin
          if (r_rd_slot == SLOT_W'(WINDOW - 1)) begin
            r_rd_en <= 1'b0;
            r_state <= DRAIN;
          end else begin
            r_rd_slot <= r_rd_slot + SLOT_W'(1);
          end
        end
        DRAIN: begin
          r_res_valid <= 1'b1;
          r_state     <= HOLD;
        end
        HOLD: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Accumulator registers double as the result hold registers: they only
  // change during a sweep, so they stay stable throughout HOLD.
  window_accum u_accum (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_start),
    .i_valid (r_rd_en_d),
    .i_first (r_first_d),
    .i_data  (rd_data),
    .o_sum   (res_sum),
    .o_min   (res_min),
    .o_max   (res_max)
  );

  assign req_ready = r_req_ready;
  assign rd_en     = r_rd_en;
  assign rd_chan   = r_rd_chan;
  assign rd_slot   = r_rd_slot;
  assign res_valid = r_res_valid;
  assign res_chan  = r_res_chan;
  assign res_err   = r_res_err;

endmodule

// File: tb/tb_channel_window_stats.sv
module tb_channel_window_stats;
  import ch_stats_pkg::*;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   req_valid;
  logic                   req_ready;
  logic [CH_W-1:0]        req_chan;
  logic                   rd_en;
  logic [CH_W-1:0]        rd_chan;
  logic [SLOT_W-1:0]      rd_slot;
  logic [SAMPLE_BITS-1:0] rd_data = '0;
  logic                   res_valid;
  logic                   res_ready;
  logic [CH_W-1:0]        res_chan;
  logic [SUM_W-1:0]       res_sum;
  logic [SAMPLE_BITS-1:0] res_min;
  logic [SAMPLE_BITS-1:0] res_max;
  logic                   res_err;

  channel_window_stats dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_chan(req_chan),
    .rd_en(rd_en), .rd_chan(rd_chan), .rd_slot(rd_slot), .rd_data(rd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_chan(res_chan),
    .res_sum(res_sum), .res_min(res_min), .res_max(res_max), .res_err(res_err)
  );

  always #5 clk = ~clk;

  // Sample buffer model with synchronous read port.
  logic [SAMPLE_BITS-1:0] mem [NUM_CHANNELS][WINDOW];
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_chan][rd_slot];

  // Cycle counter and read-port monitor.
  int   cyc = 0;
  int   rd_cnt = 0;
  int   rd_first = -1;
  int   slot_bad = 0;
  int   slot_exp = 0;
  logic rd_en_prev = 1'b0;
  always @(posedge clk) begin
    if (rd_en) begin
      if (!rd_en_prev) rd_first <= cyc;
      if (int'(rd_slot) != (rd_en_prev ? slot_exp + 1 : 0)) slot_bad <= slot_bad + 1;
      slot_exp <= rd_en_prev ? slot_exp + 1 : 0;
      rd_cnt <= rd_cnt + 1;
    end
    rd_en_prev <= rd_en;
    cyc <= cyc + 1;
  end

  typedef struct {
    int chan; int sum; int mn; int mx; int err; int lat; int t;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic exp_t model(int ch, int t);
    exp_t e;
    e.chan = ch; e.t = t;
    if (ch >= NUM_CHANNELS) begin
      e.err = 1; e.sum = 0; e.mn = 0; e.mx = 0; e.lat = 1;
    end else begin
      e.err = 0; e.sum = 0; e.mn = 255; e.mx = 0; e.lat = WINDOW + 2;
      for (int s = 0; s < WINDOW; s++) begin
        e.sum += int'(mem[ch][s]);
        if (int'(mem[ch][s]) < e.mn) e.mn = int'(mem[ch][s]);
        if (int'(mem[ch][s]) > e.mx) e.mx = int'(mem[ch][s]);
      end
    end
    return e;
  endfunction

  task automatic do_req(int ch, bit push, output int t_acc);
    @(negedge clk);
    req_valid = 1'b1;
    req_chan  = ch[CH_W-1:0];
    check("req_ready_at_req", req_ready, 1);
    t_acc = cyc;
    if (push) sb.push_back(model(ch, t_acc));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_result(int budget);
    exp_t e;
    int   k;
    k = 0;
    while (res_valid !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (res_valid !== 1'b1) begin
      check("res_valid_timeout", res_valid, 1);
      return;
    end
    if (sb.size() == 0) begin
      check("unexpected_result", res_valid, 0);
      return;
    end
    e = sb.pop_front();
    check("latency",  cyc - e.t, e.lat);
    check("res_chan", res_chan, e.chan);
    check("res_sum",  res_sum,  e.sum);
    check("res_min",  res_min,  e.mn);
    check("res_max",  res_max,  e.mx);
    check("res_err",  res_err,  e.err);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t, t1, t2, base, k;
    exp_t e7;

    for (int c = 0; c < NUM_CHANNELS; c++)
      for (int s = 0; s < WINDOW; s++)
        mem[c][s] = SAMPLE_BITS'($urandom_range(0, 255));
    for (int s = 0; s < WINDOW; s++) begin
      mem[3][s]  = SAMPLE_BITS'(s + 1);
      mem[13][s] = 8'hFF;
      mem[0][s]  = 8'h00;
    end

    reset = 1'b1; req_valid = 1'b0; req_chan = '0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_req_ready", req_ready, 1);
    check("rst_rd_en",     rd_en,     0);
    check("rst_rd_slot",   rd_slot,   0);
    check("rst_rd_chan",   rd_chan,   0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_sum",   res_sum,   0);
    check("rst_res_err",   res_err,   0);

    // Ch 3 = 1..10
    base = rd_cnt;
    do_req(3, 1, t);
    wait_result(20);
    check("ch3_rd_first", rd_first, t + 1);
    check("ch3_rd_count", rd_cnt - base, WINDOW);
    check("ch3_slot_seq", slot_bad, 0);

    // Ch 13 all 0xFF, ch 0 all zero
    do_req(13, 1, t);
    wait_result(20);
    do_req(0, 1, t);
    wait_result(20);

    // Out-of-range channels
    base = rd_cnt;
    do_req(14, 1, t);
    wait_result(5);
    do_req(15, 1, t);
    wait_result(5);
    @(negedge clk);
    check("err_no_rd", rd_cnt - base, 0);

    // Stall in HOLD
    base = rd_cnt;
    res_ready = 1'b0;
    do_req(7, 1, t);
    e7 = model(7, t);
    wait_result(20);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_chan  = CH_W'(2);
      @(negedge clk);
      check("stall_res_valid", res_valid, 1);
      check("stall_res_sum",   res_sum,   e7.sum);
      check("stall_res_min",   res_min,   e7.mn);
      check("stall_res_max",   res_max,   e7.mx);
      check("stall_res_chan",  res_chan,  7);
      check("stall_req_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check("release_res_valid", res_valid, 0);
    check("release_req_ready", req_ready, 1);
    repeat (3) @(negedge clk);
    check("stall_no_extra_rd", rd_cnt - base, WINDOW);
    check("stall_no_ghost",    res_valid, 0);

    // Back-to-back ch 2 then ch 5
    base = rd_cnt;
    @(negedge clk);
    req_valid = 1'b1;
    req_chan  = CH_W'(2);
    check("b2b_req_ready_1", req_ready, 1);
    t1 = cyc;
    sb.push_back(model(2, t1));
    @(negedge clk);
    req_chan = CH_W'(5);
    wait_result(20);
    check("b2b_rd_first_1", rd_first, t1 + 1);
    k = 0;
    while (req_ready !== 1'b1 && k < 5) begin
      @(negedge clk);
      k++;
    end
    check("b2b_req_ready_2", req_ready, 1);
    t2 = cyc;
    check("b2b_spacing", t2 - t1, WINDOW + 3);
    sb.push_back(model(5, t2));
    @(negedge clk);
    req_valid = 1'b0;
    wait_result(20);
    check("b2b_rd_first_2", rd_first, t2 + 1);
    check("b2b_rd_count",   rd_cnt - base, 2 * WINDOW);

    // Reset mid-sweep
    do_req(9, 0, t);
    @(negedge clk);
    check("mid_sweep_rd_en", rd_en, 1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    base = rd_cnt;
    check("abort_res_valid", res_valid, 0);
    check("abort_rd_en",     rd_en,     0);
    check("abort_req_ready", req_ready, 1);
    repeat (15) @(negedge clk);
    check("abort_no_result", res_valid, 0);
    check("abort_no_rd",     rd_cnt - base, 0);

    do_req(3, 1, t);
    wait_result(20);
    check("slot_seq_final", slot_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
